layer_input_feeder: RTL
=======================

LAYER_INPUT_FEEDER -- requirements
Module: layer_input_feeder

Interface
REQ-001 SHALL have parameter N_IN, default 15, number of parallel activations presented per frame.
REQ-002 SHALL have parameter DATA_W, default 32, activation word width.
REQ-003 SHALL have parameter HOLD_CYC, default 2, minimum cycles a delivered frame stays stable; covers the 2-cycle node pipeline.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 s_data  in  DATA_W  serial activation word, element 0 first.
REQ-007 s_valid  in  1  s_data valid.
REQ-008 s_ready  out  1  feeder accepts s_data this cycle.
REQ-009 s_last  in  1  marks element N_IN-1 of a frame.
REQ-010 a_out  out  N_IN*DATA_W  parallel activations; slice k (bits k*DATA_W +: DATA_W) drives node input Akx.
REQ-011 a_valid  out  1  one-cycle pulse, first cycle a new frame is on a_out.
REQ-012 frame_err  out  1  one-cycle pulse on frame-length mismatch.

Function
REQ-013 Transfer SHALL occur on a cycle with s_valid=1 and s_ready=1; no other cycle alters fill state.
REQ-014 Element index counter idx (0..N_IN-1) SHALL select the shadow slot written; it increments per transfer and wraps to 0 after index N_IN-1.
REQ-015 On transfer of index N_IN-1, a_out SHALL load all N_IN elements (shadow 0..N_IN-2 plus current s_data) on the next edge; a_valid SHALL be 1 for exactly that following cycle.
REQ-016 Latency: last-element transfer at edge t -> a_out updated and a_valid=1 in cycle t+1.
REQ-017 a_out SHALL hold its value between updates; no partial update ever visible.
REQ-018 Hold counter SHALL load HOLD_CYC on each a_out update and decrement to 0.
REQ-019 s_ready SHALL be 0 only when idx=N_IN-1 and hold counter is nonzero; otherwise 1; frames 0..N_IN-2 fill concurrently with hold.
REQ-020 States: FILL (idx<N_IN-1), LAST (idx=N_IN-1, ready gated by hold), back to FILL on completion.
REQ-021 Data SHALL pass bit-exact; no arithmetic, sign handling or truncation.
REQ-022 s_valid deasserted mid-frame SHALL leave idx and shadow unchanged (gaps allowed).

Reset
REQ-023 reset=0 at an edge SHALL clear a_out to 0, a_valid and frame_err to 0, idx to 0, hold counter to 0, shadow to 0.
REQ-024 Reset mid-frame SHALL discard the partial frame; first transfer after reset release is element 0.
REQ-025 s_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-026 Macro LAYER_FEEDER_LAST_CHECK_EN defined: s_last=1 at idx<N_IN-1, or s_last=0 at idx=N_IN-1, SHALL pulse frame_err next cycle, discard the frame (a_out unchanged, no a_valid), and reset idx to 0.
REQ-027 Macro undefined: s_last SHALL be ignored, frame_err tied 0, framing by idx count only.

Structure
REQ-028 Shared package (nn_pkg) SHALL hold DATA_W default, N_IN default, HOLD_CYC default and the FILL/LAST state enum.
REQ-029 Sub-module hold_timer (load/decrement/zero-flag counter) SHALL be the single instantiated sub-module; shadow and output registers stay in layer_input_feeder.

Verification
REQ-030 Back-to-back frame values 1..15 with s_last on 15th -> a_out slice k = k+1, a_valid single pulse one cycle after 15th transfer.
REQ-031 Second frame 101..115 streamed immediately -> s_ready=0 while idx=14 and hold nonzero, first a_out stays 1..15 for >=2 cycles, then 101..115 with one a_valid pulse.
REQ-032 Check enabled, s_last asserted on 10th word -> frame_err pulse, a_out unchanged, next 15 words form a clean frame.
REQ-033 reset=0 after 7 words of a frame -> a_out=0, idx=0; subsequent full frame 0xFFFF_0000.. delivered correctly.
REQ-034 s_valid toggled 1/0 every cycle through a frame of 0x8000_0001 values -> output identical to gapless case, a_valid once.
REQ-035 Check disabled, s_last held 0 for 15 words -> frame delivered, frame_err stays 0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the layer input feeder: default geometry, hold time
// and the fill-state encoding.
package nn_pkg;

    localparam int N_IN_DEF     = 15;
    localparam int DATA_W_DEF   = 32;
    localparam int HOLD_CYC_DEF = 2;

    typedef enum logic {
        FILL = 1'b0,
        LAST = 1'b1
    } feed_state_t;

    // Counter width that can represent 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_input_feeder_if.sv
// Serial-in / parallel-out bus of the layer input feeder. master is the
// activation source (and frame consumer), slave is the feeder itself.
interface layer_input_feeder_if
    import nn_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [DATA_W-1:0]      s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic                   s_last;
    logic [N_IN*DATA_W-1:0] a_out;
    logic                   a_valid;
    logic                   frame_err;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready,
        input  a_out,
        input  a_valid,
        input  frame_err
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready,
        output a_out,
        output a_valid,
        output frame_err
    );

endinterface

// File: rtl/hold_timer.sv
// Load / decrement-to-zero counter; zero is high whenever the count is 0.
module hold_timer
    import nn_pkg::*;
#(
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic zero
);

    localparam int CNT_W = width_of(HOLD_CYC + 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= CNT_W'(HOLD_CYC);
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/layer_input_feeder.sv
// Collects N_IN serial activation words into a shadow buffer and publishes them
// as one parallel frame; optional s_last framing check under LAYER_FEEDER_LAST_CHECK_EN.
module layer_input_feeder
    import nn_pkg::*;
#(
    parameter int N_IN     = N_IN_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    layer_input_feeder_if.slave  bus
);

    localparam int IDX_W = width_of(N_IN);
    localparam logic [IDX_W-1:0] IDX_PRE_LAST = IDX_W'(N_IN - 2);

    feed_state_t            state_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [DATA_W-1:0]      shadow_reg [N_IN-1];
    logic [N_IN*DATA_W-1:0] a_out_reg;
    logic                   a_valid_reg;
    logic                   frame_err_reg;

    logic                   xfer;
    logic                   at_last;
    logic                   len_err;
    logic                   frame_done;
    logic                   shadow_wr;
    logic                   hold_zero;
    logic [N_IN*DATA_W-1:0] a_load;

    assign at_last = (state_reg == LAST);
    assign xfer    = bus.s_valid && bus.s_ready;

`ifdef LAYER_FEEDER_LAST_CHECK_EN
    // Only transferred words are judged; s_last on idle cycles is don't-care.
    assign len_err = xfer && (bus.s_last != at_last);
`else
    logic unused_last;
    assign unused_last = bus.s_last;
    assign len_err     = 1'b0;
`endif

    assign frame_done = xfer && at_last && !len_err;
    assign shadow_wr  = xfer && !at_last && !len_err;

    // The final element bypasses the shadow and goes straight into a_out.
    always_comb begin
        a_load = '0;
        for (int i = 0; i < N_IN - 1; i++) begin
            a_load[i*DATA_W +: DATA_W] = shadow_reg[i];
        end
        a_load[(N_IN-1)*DATA_W +: DATA_W] = bus.s_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_IN - 1; i++) begin
                shadow_reg[i] <= '0;
            end
        end else if (shadow_wr) begin
            shadow_reg[idx_reg] <= bus.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= FILL;
            idx_reg       <= '0;
            a_out_reg     <= '0;
            a_valid_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            a_valid_reg   <= frame_done;
            frame_err_reg <= len_err;
            if (frame_done) begin
                a_out_reg <= a_load;
            end
            if (len_err) begin
                state_reg <= FILL;
                idx_reg   <= '0;
            end else if (xfer) begin
                case (state_reg)
                    FILL: begin
                        idx_reg <= idx_reg + 1'b1;
                        if (idx_reg == IDX_PRE_LAST) begin
                            state_reg <= LAST;
                        end
                    end
                    LAST: begin
                        idx_reg   <= '0;
                        state_reg <= FILL;
                    end
                    default: begin
                        idx_reg   <= '0;
                        state_reg <= FILL;
                    end
                endcase
            end
        end
    end

    hold_timer #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .load  (frame_done),
        .zero  (hold_zero)
    );

    // Early elements keep streaming during hold; only the frame-completing word waits.
    assign bus.s_ready   = !at_last || hold_zero;
    assign bus.a_out     = a_out_reg;
    assign bus.a_valid   = a_valid_reg;
    assign bus.frame_err = frame_err_reg;

endmodule
